// File: rtl/edge_request_arbiter.sv
// Round-robin arbiter that turns rising edges on N_REQ request lines into
// fixed-length strobes on one shared channel, with a guard gap after each strobe.
module edge_request_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [N_REQ-1:0] REQ_LEVEL,
   input  logic             READY,
   output logic             STROBE,
   output logic [N_REQ-1:0] GRANT_ONEHOT,
   output logic [ID_W-1:0]  GRANT_ID,
   output logic [N_REQ-1:0] PENDING,
   output logic [N_REQ-1:0] OVERRUN
);

   localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int SUM_W   = ID_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0]  rr_ptr;
   logic [N_REQ-1:0] prev_level;
   logic [N_REQ-1:0] req_edge;
   logic [N_REQ-1:0] grant_clear;
   logic [N_REQ-1:0] winner_onehot;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  scan_idx;
   logic [SUM_W-1:0] scan_sum;
   logic             win_valid;
   logic             do_grant;

   assign req_edge = ~prev_level & REQ_LEVEL;

   // Scan from the round-robin pointer, wrapping at N_REQ, for the first pending line.
   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      win_valid = 1'b0;
      winner    = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (scan_sum >= SUM_W'(N_REQ))
            scan_sum = scan_sum - SUM_W'(N_REQ);
         scan_idx = scan_sum[ID_W-1:0];
         if (!win_valid && PENDING[scan_idx]) begin
            win_valid = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   assign winner_onehot = N_REQ'(1) << winner;
   assign do_grant      = (state == S_IDLE) && READY && win_valid;
   assign grant_clear   = do_grant ? winner_onehot : '0;

   // History resets to all ones so a line already high at reset release is not an edge.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         prev_level <= '1;
         PENDING    <= '0;
         OVERRUN    <= '0;
      end else begin
         prev_level <= REQ_LEVEL;
         PENDING    <= (PENDING & ~grant_clear) | req_edge;
         OVERRUN    <= req_edge & PENDING & ~grant_clear;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state        <= S_IDLE;
         cnt          <= '0;
         rr_ptr       <= '0;
         STROBE       <= 1'b0;
         GRANT_ONEHOT <= '0;
         GRANT_ID     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (do_grant) begin
                  state        <= S_STROBE;
                  cnt          <= CNT_W'(PULSE_LEN - 1);
                  STROBE       <= 1'b1;
                  GRANT_ONEHOT <= winner_onehot;
                  GRANT_ID     <= winner;
                  rr_ptr       <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
               end
            end
            S_STROBE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  STROBE <= 1'b0;
                  if (GAP_LEN > 0) begin
                     state <= S_GAP;
                     cnt   <= CNT_W'(GAP_LEN - 1);
                  end else begin
                     state        <= S_IDLE;
                     GRANT_ONEHOT <= '0;
                  end
               end
            end
            S_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state        <= S_IDLE;
                  GRANT_ONEHOT <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_request_arbiter.sv
// Directed table-driven bench for edge_request_arbiter: one instance with the default
// timing and one with PULSE_LEN=1, GAP_LEN=0, sharing clock and reset.
module tb_edge_request_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req6;
   logic       ready, ready6;
   logic       strobe, strobe6;
   logic [3:0] oh, oh6, pend, pend6, ovr, ovr6;
   logic [1:0] id, id6;

   always #5 clk = ~clk;

   edge_request_arbiter #(.N_REQ(4), .ID_W(2), .PULSE_LEN(4), .GAP_LEN(2)) u_dut (
      .CLOCK(clk), .RESET(rst_n), .REQ_LEVEL(req), .READY(ready), .STROBE(strobe),
      .GRANT_ONEHOT(oh), .GRANT_ID(id), .PENDING(pend), .OVERRUN(ovr));

   edge_request_arbiter #(.N_REQ(4), .ID_W(2), .PULSE_LEN(1), .GAP_LEN(0)) u_dut6 (
      .CLOCK(clk), .RESET(rst_n), .REQ_LEVEL(req6), .READY(ready6), .STROBE(strobe6),
      .GRANT_ONEHOT(oh6), .GRANT_ID(id6), .PENDING(pend6), .OVERRUN(ovr6));

   // One row: inputs held for n cycles; outputs expected after each of those cycles.
   typedef struct {
      bit         sel;
      logic       rst;
      logic [3:0] req;
      logic       ready;
      int         n;
      logic       strobe;
      logic [3:0] oh;
      logic [1:0] id;
      logic [3:0] pend;
      logic [3:0] ovr;
   } row_t;

   row_t rows[$];
   int   checks   = 0;
   int   failures = 0;
   int   split_idx;

   function automatic void add(input bit sel, input logic rst, input logic [3:0] rq,
                               input logic rdy, input int n, input logic s,
                               input logic [3:0] o_h, input logic [1:0] o_id,
                               input logic [3:0] p, input logic [3:0] o_v);
      row_t r;
      r.sel = sel; r.rst = rst; r.req = rq; r.ready = rdy; r.n = n;
      r.strobe = s; r.oh = o_h; r.id = o_id; r.pend = p; r.ovr = o_v;
      rows.push_back(r);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i < last; i++) begin
         for (int k = 0; k < rows[i].n; k++) begin
            rst_n = rows[i].rst;
            if (rows[i].sel) begin
               req6 = rows[i].req; ready6 = rows[i].ready;
            end else begin
               req = rows[i].req; ready = rows[i].ready;
            end
            @(posedge clk);
            @(negedge clk);
            if (rows[i].sel) begin
               check($sformatf("row%0d.%0d strobe6", i, k), 32'(strobe6), 32'(rows[i].strobe));
               check($sformatf("row%0d.%0d onehot6", i, k), 32'(oh6), 32'(rows[i].oh));
               check($sformatf("row%0d.%0d id6", i, k), 32'(id6), 32'(rows[i].id));
               check($sformatf("row%0d.%0d pending6", i, k), 32'(pend6), 32'(rows[i].pend));
               check($sformatf("row%0d.%0d overrun6", i, k), 32'(ovr6), 32'(rows[i].ovr));
            end else begin
               check($sformatf("row%0d.%0d strobe", i, k), 32'(strobe), 32'(rows[i].strobe));
               check($sformatf("row%0d.%0d onehot", i, k), 32'(oh), 32'(rows[i].oh));
               check($sformatf("row%0d.%0d id", i, k), 32'(id), 32'(rows[i].id));
               check($sformatf("row%0d.%0d pending", i, k), 32'(pend), 32'(rows[i].pend));
               check($sformatf("row%0d.%0d overrun", i, k), 32'(ovr), 32'(rows[i].ovr));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req6 = '0; ready = 1'b1; ready6 = 1'b1;

      // Single request on line 2: one 4-cycle strobe, 2-cycle gap, no repeat while held.
      add(0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0100, 1, 1, 0, 4'b0000, 0, 4'b0100, 4'b0000);
      add(0, 1, 4'b0100, 1, 4, 1, 4'b0100, 2, 4'b0000, 4'b0000);
      add(0, 1, 4'b0100, 1, 2, 0, 4'b0100, 2, 4'b0000, 4'b0000);
      add(0, 1, 4'b0100, 1, 3, 0, 4'b0000, 2, 4'b0000, 4'b0000);

      // Round robin over all four lines, then lines 0 and 3 again after the wrap.
      add(0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b1111, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b0001, 0, 4'b1110, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b0001, 0, 4'b1110, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b1110, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b0010, 1, 4'b1100, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b0010, 1, 4'b1100, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 1, 4'b1100, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b0100, 2, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b0100, 2, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 2, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b1000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b1000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b0110, 1, 1, 0, 4'b0000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 3, 4'b1001, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b0001, 0, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b0001, 0, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b1000, 4'b0000);
      add(0, 1, 4'b1111, 1, 4, 1, 4'b1000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 2, 0, 4'b1000, 3, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 1, 0, 4'b0000, 3, 4'b0000, 4'b0000);

      // Overrun: second edge on line 1 while still pending and READY low.
      add(0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0010, 0, 1, 0, 4'b0000, 0, 4'b0010, 4'b0000);
      add(0, 1, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0010, 4'b0000);
      add(0, 1, 4'b0010, 0, 1, 0, 4'b0000, 0, 4'b0010, 4'b0010);
      add(0, 1, 4'b0010, 0, 2, 0, 4'b0000, 0, 4'b0010, 4'b0000);
      add(0, 1, 4'b0010, 1, 4, 1, 4'b0010, 1, 4'b0000, 4'b0000);
      add(0, 1, 4'b0010, 1, 2, 0, 4'b0010, 1, 4'b0000, 4'b0000);
      add(0, 1, 4'b0010, 1, 3, 0, 4'b0000, 1, 4'b0000, 4'b0000);

      // Re-arm: new edge on line 0 during its own strobe.
      add(0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0001, 4'b0000);
      add(0, 1, 4'b0001, 1, 1, 1, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 1, 1, 1, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 1, 2, 1, 4'b0001, 0, 4'b0001, 4'b0000);
      add(0, 1, 4'b0001, 1, 2, 0, 4'b0001, 0, 4'b0001, 4'b0000);
      add(0, 1, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0001, 4'b0000);
      add(0, 1, 4'b0001, 1, 4, 1, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 1, 2, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);

      // Lines held high through reset release give no request; then start a strobe.
      add(0, 0, 4'b1111, 1, 2, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b1111, 1, 3, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0001, 4'b0000);
      add(0, 1, 4'b0001, 1, 2, 1, 4'b0001, 0, 4'b0000, 4'b0000);
      split_idx = rows.size();

      // PULSE_LEN=1, GAP_LEN=0: 1-cycle strobes with one idle cycle between.
      add(1, 0, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(1, 1, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(1, 1, 4'b0011, 1, 1, 0, 4'b0000, 0, 4'b0011, 4'b0000);
      add(1, 1, 4'b0011, 1, 1, 1, 4'b0001, 0, 4'b0010, 4'b0000);
      add(1, 1, 4'b0011, 1, 1, 0, 4'b0000, 0, 4'b0010, 4'b0000);
      add(1, 1, 4'b0011, 1, 1, 1, 4'b0010, 1, 4'b0000, 4'b0000);
      add(1, 1, 4'b0011, 1, 2, 0, 4'b0000, 1, 4'b0000, 4'b0000);

      run_rows(0, split_idx);

      // Mid-strobe reset between clock edges must clear outputs without waiting for a clock.
      #2 rst_n = 1'b0;
      #1;
      check("async_reset strobe", 32'(strobe), 32'd0);
      check("async_reset onehot", 32'(oh), 32'd0);
      check("async_reset pending", 32'(pend), 32'd0);
      check("async_reset id", 32'(id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_reset strobe", 32'(strobe), 32'd0);
      check("post_reset pending", 32'(pend), 32'd0);

      run_rows(split_idx, rows.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
